// File: rtl/mod12_count_checker.sv
// mod12_count_checker: predicts the next mod-12 counter value from the counter's
// control inputs and flags mismatches and out-of-range values.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   load       counter load strobe
//   mode       counter direction (1 = up, 0 = down)
//   datain     counter load value
//   count      observed counter output
//   expected   predicted count for the current cycle
//   locked     prediction valid, comparison active
//   err        one-cycle pulse on mismatch or range error
//   range_err  one-cycle pulse when count >= MODULUS
//   err_cnt    saturating error total
//
// Optional build macro MOD12_CHK_CAPTURE_EN adds:
//   cap_exp    expected value at the first error after reset
//   cap_obs    observed count at the first error after reset
//   cap_valid  set once a capture has been taken, held until rst
module mod12_count_checker #(
  parameter int MODULUS = 12,
  parameter int WIDTH   = 4,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] datain,
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] expected,
  output logic             locked,
  output logic             err,
  output logic             range_err,
  output logic [ERR_W-1:0] err_cnt
`ifdef MOD12_CHK_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] cap_exp,
  output logic [WIDTH-1:0] cap_obs,
  output logic             cap_valid
`endif
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] expected_q;
  logic             locked_q;
  logic             err_q;
  logic             range_q;
  logic [ERR_W-1:0] err_cnt_q;

  logic             range_hit;
  logic             miss;
  logic             err_now;
  logic [WIDTH-1:0] count_eff;
  logic [WIDTH-1:0] pred_d;
  logic [WIDTH-1:0] pred_init;
  logic [ERR_W-1:0] err_cnt_d;

  // Next-count prediction; a load with an
  // out-of-range value is ignored, as the
  // counter itself ignores it.
  function automatic logic [WIDTH-1:0] nxt(
    input logic [WIDTH-1:0] c,
    input logic             ld,
    input logic             up,
    input logic [WIDTH-1:0] di
  );
    logic [WIDTH-1:0] r;
    if (ld && ({1'b0, di} < MOD_W)) begin
      r = di;
    end else if (up) begin
      r = (c == MAX_V) ? '0 : c + WIDTH'(1);
    end else begin
      r = (c == '0) ? MAX_V : c - WIDTH'(1);
    end
    return r;
  endfunction

  always_comb begin
    range_hit = ({1'b0, count} >= MOD_W);
    miss      = (count != expected_q);
    // An out-of-range observation restarts
    // the prediction from zero.
    count_eff = range_hit ? '0 : count;
    pred_d    = nxt(count_eff, load, mode, datain);
    pred_init = nxt('0, load, mode, datain);
    err_cnt_d = (&err_cnt_q) ? err_cnt_q
                             : err_cnt_q + ERR_W'(1);
    err_now   = 1'b0;
    unique case (1'b1)
      (state_q == TRACK):  err_now = range_hit | miss;
      (state_q == RESYNC): err_now = range_hit;
      default:             err_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      expected_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      range_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Counter leaves reset at 0.
          expected_q <= pred_init;
          locked_q   <= 1'b1;
          err_q      <= 1'b0;
          range_q    <= 1'b0;
          state_q    <= TRACK;
        end
        TRACK: begin
          expected_q <= pred_d;
          err_q      <= err_now;
          range_q    <= range_hit;
          if (err_now) begin
            err_cnt_q <= err_cnt_d;
            locked_q  <= 1'b0;
            state_q   <= RESYNC;
          end else begin
            locked_q  <= 1'b1;
            state_q   <= TRACK;
          end
        end
        RESYNC: begin
          // Re-seed from the observed value;
          // only a range error counts here.
          expected_q <= pred_d;
          err_q      <= err_now;
          range_q    <= range_hit;
          if (err_now) begin
            err_cnt_q <= err_cnt_d;
            locked_q  <= 1'b0;
            state_q   <= RESYNC;
          end else begin
            locked_q  <= 1'b1;
            state_q   <= TRACK;
          end
        end
        default: begin
          expected_q <= '0;
          locked_q   <= 1'b0;
          err_q      <= 1'b0;
          range_q    <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign expected  = expected_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign range_err = range_q;
  assign err_cnt   = err_cnt_q;

`ifdef MOD12_CHK_CAPTURE_EN
  logic [WIDTH-1:0] cap_exp_q;
  logic [WIDTH-1:0] cap_obs_q;
  logic             cap_valid_q;

  // Only the first error after reset
  // is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_exp_q   <= '0;
      cap_obs_q   <= '0;
      cap_valid_q <= 1'b0;
    end else if (err_now && !cap_valid_q) begin
      cap_exp_q   <= expected_q;
      cap_obs_q   <= count;
      cap_valid_q <= 1'b1;
    end
  end

  assign cap_exp   = cap_exp_q;
  assign cap_obs   = cap_obs_q;
  assign cap_valid = cap_valid_q;
`endif

endmodule

// File: tb/tb_mod12_count_checker.sv
// tb_mod12_count_checker: directed and random stimulus
// against a cycle-level reference model.
module tb_mod12_count_checker;

  localparam int M  = 12;
  localparam int W  = 4;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic          mode;
  logic [W-1:0]  datain;
  logic [W-1:0]  count;
  logic [W-1:0]  expected;
  logic          locked;
  logic          err;
  logic          range_err;
  logic [EW-1:0] err_cnt;
`ifdef MOD12_CHK_CAPTURE_EN
  logic [W-1:0]  cap_exp;
  logic [W-1:0]  cap_obs;
  logic          cap_valid;
`endif

  always #5 clk = ~clk;

  mod12_count_checker #(
    .MODULUS(M),
    .WIDTH  (W),
    .ERR_W  (EW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .mode     (mode),
    .datain   (datain),
    .count    (count),
    .expected (expected),
    .locked   (locked),
    .err      (err),
    .range_err(range_err),
    .err_cnt  (err_cnt)
`ifdef MOD12_CHK_CAPTURE_EN
    ,
    .cap_exp  (cap_exp),
    .cap_obs  (cap_obs),
    .cap_valid(cap_valid)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;
  int n_fail = 0;

  int m_exp, m_locked, m_err, m_rerr;
  int m_cnt, m_started;
  int m_cexp, m_cobs, m_cval;
  int ctr;

  function automatic int f(int c, bit ld,
                           bit md, int di);
    if (ld && di < M) return di;
    if (md) return (c + 1) % M;
    return (c + M - 1) % M;
  endfunction

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d",
             tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int c;
    bit rng, bad;
    c = int'(count);
    if (rst) begin
      m_exp = 0; m_locked = 0;
      m_err = 0; m_rerr = 0;
      m_cnt = 0; m_started = 0;
      m_cexp = 0; m_cobs = 0; m_cval = 0;
    end else if (m_started == 0) begin
      m_exp = f(0, load, mode, int'(datain));
      m_locked = 1; m_err = 0; m_rerr = 0;
      m_started = 1;
    end else begin
      rng = (c >= M);
      bad = rng || (m_locked == 1 && c != m_exp);
      if (bad && m_cval == 0) begin
        m_cexp = m_exp; m_cobs = c; m_cval = 1;
      end
      m_err  = bad ? 1 : 0;
      m_rerr = rng ? 1 : 0;
      if (bad && m_cnt < 255) m_cnt++;
      m_exp = f(rng ? 0 : c, load, mode,
                int'(datain));
      m_locked = bad ? 0 : 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("expected",  32'(expected),  32'(m_exp));
    chk("locked",    32'(locked),    32'(m_locked));
    chk("err",       32'(err),       32'(m_err));
    chk("range_err", 32'(range_err), 32'(m_rerr));
    chk("err_cnt",   32'(err_cnt),   32'(m_cnt));
`ifdef MOD12_CHK_CAPTURE_EN
    chk("cap_valid", 32'(cap_valid), 32'(m_cval));
    if (m_cval == 1) begin
      chk("cap_exp", 32'(cap_exp), 32'(m_cexp));
      chk("cap_obs", 32'(cap_obs), 32'(m_cobs));
    end
`endif
  endtask

  // One cycle of a correct counter, optionally
  // overriding what the checker observes.
  task automatic step(bit ld, bit md, int di,
                      bit ovr, int ov);
    int c;
    load   = ld;
    mode   = md;
    datain = W'(di);
    c      = ovr ? ov : ctr;
    count  = W'(c);
    cyc();
    ctr = f(c >= M ? 0 : c, ld, md, di);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1; load = 1'b0; mode = 1'b1;
    datain = '0; ctr = 0; count = '0;
    repeat (n) cyc();
    rst = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; load = 1'b0; mode = 1'b1;
    datain = '0; count = '0; ctr = 0;
    m_exp = 0; m_locked = 0; m_err = 0;
    m_rerr = 0; m_cnt = 0; m_started = 0;
    m_cexp = 0; m_cobs = 0; m_cval = 0;

    // T1: reset, then free-run up
    do_reset(3);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    step(0, 1, 0, 0, 0);
    chk("t1_lock_c2", 32'(locked), 32'd1);
    chk("t1_exp1", 32'(expected), 32'd1);
    repeat (29) step(0, 1, 0, 0, 0);
    chk("t1_errcnt0", 32'(err_cnt), 32'd0);

    // T2: wrap up, wrap down, toggling mode
    while (ctr != 11) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("t2_wrap_up", 32'(expected), 32'd0);
    chk("t2_up_noerr", 32'(err), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("t2_wrap_dn", 32'(expected), 32'd11);
    chk("t2_dn_noerr", 32'(err), 32'd0);
    for (int i = 0; i < 20; i++)
      step(0, 1'(i), 0, 0, 0);
    chk("t2_tog_cnt", 32'(err_cnt), 32'd0);

    // T3: valid and invalid loads
    step(1, 1, 3, 0, 0);
    step(1, 1, 7, 0, 0);
    chk("t3_load7", 32'(expected), 32'd7);
    step(1, 1, 4, 0, 0);
    step(1, 1, 13, 0, 0);
    chk("t3_ign13", 32'(expected), 32'd5);
    step(0, 1, 0, 1, 13);
    chk("t3_bad13", 32'(err), 32'd1);
    repeat (3) step(0, 1, 0, 0, 0);
    chk("t3_relock", 32'(locked), 32'd1);

    // T4: forced jump 5 -> 9
    do_reset(2);
    step(1, 1, 5, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("t4_exp6", 32'(expected), 32'd6);
    step(0, 1, 0, 1, 9);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_unlock", 32'(locked), 32'd0);
    chk("t4_exp10", 32'(expected), 32'd10);
    chk("t4_cnt1", 32'(err_cnt), 32'd1);
    step(0, 1, 0, 0, 0);
    chk("t4_pulse", 32'(err), 32'd0);
    chk("t4_lock", 32'(locked), 32'd1);

    // T5: out-of-range count
    repeat (2) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 14);
    chk("t5_rerr", 32'(range_err), 32'd1);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_exp1", 32'(expected), 32'd1);
    chk("t5_cnt2", 32'(err_cnt), 32'd2);
    repeat (2) step(0, 1, 0, 0, 0);

    // Random control with sparse corruption
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      step($urandom_range(0, 5) == 0,
           1'($urandom),
           int'($urandom_range(0, 15)),
           r == 0,
           int'($urandom_range(0, 15)));
    end

    // T6: error storm to saturation
    do_reset(2);
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom), 1'($urandom),
           int'($urandom_range(0, 15)), 1,
           int'($urandom_range(0, 15)));
    end
    chk("t6_sat", 32'(err_cnt), 32'd255);
    rst = 1'b1;
    count = W'($urandom_range(0, 15));
    cyc();
    chk("t6_rst_cnt", 32'(err_cnt), 32'd0);
    chk("t6_rst_lock", 32'(locked), 32'd0);
    rst = 1'b0; ctr = 0; count = '0;
    repeat (5) step(0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed",
             n_pass, n_tot);
    $finish;
  end

endmodule
